// File: rtl/otter_pkg.sv
// Shared OTTER definitions for the write-back path: FSM states, write-data select codes
// and register-file address width.
`timescale 1ns/1ps
package otter_pkg;

    localparam int RF_ADDR_W = 5;

    localparam int WB_SEL_PC4 = 0;
    localparam int WB_SEL_CSR = 1;
    localparam int WB_SEL_MEM = 2;
    localparam int WB_SEL_ALU = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_src_mux.sv
// Combinational NSRC:1 write-data selector. Any select at or above NSRC picks the last
// source, and the clamped index is returned so the caller can test which source was taken.
`timescale 1ns/1ps
module wb_src_mux #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int SEL_W = $clog2(NSRC)
) (
    input  logic [SEL_W-1:0]     i_sel,
    input  logic [NSRC*XLEN-1:0] i_src_data,
    output logic [XLEN-1:0]      o_data,
    output logic [SEL_W-1:0]     o_sel
);

    logic [XLEN-1:0] w_src [NSRC];

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_unpack
            assign w_src[gi] = i_src_data[gi*XLEN +: XLEN];
        end
    endgenerate

    // Default to the last source; only in-range selects below it override.
    always_comb begin
        o_data = w_src[NSRC-1];
        o_sel  = SEL_W'(NSRC-1);
        for (int i = 0; i < NSRC-1; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_data = w_src[i];
                o_sel  = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back stage: selects a result source, holds the instruction while a
// load is outstanding, and issues a one-cycle register-file write plus forwarding info.
`timescale 1ns/1ps
module wb_select_stage
    import otter_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NSRC    = 4,
    parameter int SEL_W   = $clog2(NSRC),
    parameter int MEM_SRC = WB_SEL_MEM
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     rf_wr_sel,
    input  logic                 rf_wr_en,
    input  logic [RF_ADDR_W-1:0] rd_addr,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic                 mem_valid,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic                 fwd_valid,
    output logic [RF_ADDR_W-1:0] fwd_addr,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 busy
);

    wb_state_t            r_state;
    logic [RF_ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]      r_data;

    logic [XLEN-1:0]      w_mux_data;
    logic [SEL_W-1:0]     w_mux_sel;
    logic [XLEN-1:0]      w_mem_data;
    logic                 w_accept;
    logic                 w_writes;
    logic                 w_sel_mem;

    wb_src_mux #(
        .XLEN  (XLEN),
        .NSRC  (NSRC),
        .SEL_W (SEL_W)
    ) u_src_mux (
        .i_sel      (rf_wr_sel),
        .i_src_data (src_data),
        .o_data     (w_mux_data),
        .o_sel      (w_mux_sel)
    );

    assign w_mem_data = src_data[MEM_SRC*XLEN +: XLEN];
    assign w_accept   = in_valid && (r_state != WAIT_MEM);
    assign w_writes   = rf_wr_en && (rd_addr != '0);
    assign w_sel_mem  = (w_mux_sel == SEL_W'(MEM_SRC));

    // Requests that write nothing (disabled or x0) are consumed without leaving IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                WAIT_MEM: begin
                    if (mem_valid) begin
                        r_data  <= w_mem_data;
                        r_state <= WRITE;
                    end
                end
                default: begin
                    if (w_accept && w_writes) begin
                        r_addr <= rd_addr;
                        if (!w_sel_mem || mem_valid) begin
                            r_data  <= w_mux_data;
                            r_state <= WRITE;
                        end else begin
                            r_state <= WAIT_MEM;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Held low while reset is asserted so nothing upstream launches into a resetting stage.
    assign in_ready  = !rst && (r_state != WAIT_MEM);
    assign busy      = (r_state == WAIT_MEM);

    assign rf_we     = (r_state == WRITE);
    assign rf_wa     = r_addr;
    assign rf_wd     = r_data;
    assign fwd_valid = (r_state == WRITE);
    assign fwd_addr  = r_addr;
    assign fwd_data  = r_data;

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Parametrised, registered write-back stage for the OTTER register file. It selects one of `NSRC` result sources, registers the selected value, and issues a single-cycle register-file write. Memory loads may return data cycles after the instruction arrives; the stage holds the instruction until the data is valid. It sits between execute/memory and the register file, and exposes the pending write for hazard forwarding.

## Interface

Parameters:
- `XLEN`, 32, data width.
- `NSRC`, 4, number of write-data sources (≥2).
- `SEL_W`, `$clog2(NSRC)`, select width (derived; do not override).
- `MEM_SRC`, 2, source index whose data may arrive late (memory `DOUT2`).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: write-back request presented.
- `in_ready` out 1: stage can accept a request this cycle.
- `rf_wr_sel` in `SEL_W`: source select. Values ≥ `NSRC` select source `NSRC-1`.
- `rf_wr_en` in 1: instruction writes a register.
- `rd_addr` in 5: destination register.
- `src_data` in `NSRC*XLEN`: packed sources. Source i occupies `[i*XLEN +: XLEN]`.
- `mem_valid` in 1: source `MEM_SRC` holds valid load data this cycle.
- `rf_we` out 1: register-file write strobe, one cycle.
- `rf_wa` out 5: write address.
- `rf_wd` out `XLEN`: write data.
- `fwd_valid` out 1: a write is pending or issuing, and `fwd_data` is valid.
- `fwd_addr` out 5: destination of that write.
- `fwd_data` out `XLEN`: data of that write.
- `busy` out 1: stage is waiting on memory.

## Operation

- FSM states: `IDLE`, `WAIT_MEM`, `WRITE`.
- **IDLE**
  - `in_ready=1`.
  - Accept happens on `in_valid`.
  - If `rf_wr_en=0` or `rd_addr=0`, the request is consumed and no write occurs; stay in `IDLE`.
  - If `sel≠MEM_SRC`, or `sel=MEM_SRC` with `mem_valid=1` in the same cycle: latch the address and selected data, then go to `WRITE`.
  - If `sel=MEM_SRC` with `mem_valid=0`: latch the address and go to `WAIT_MEM`.
- **WAIT_MEM**
  - `in_ready=0`, `busy=1`.
  - On `mem_valid`: latch source `MEM_SRC` and go to `WRITE`.
  - No timeout.
- **WRITE**
  - `rf_we=1` for exactly this cycle, with `rf_wa`/`rf_wd` from the latched values.
  - `in_ready=1`, so a new request can be accepted back-to-back using the same rules as `IDLE`.
  - Next state is `WRITE`, `WAIT_MEM` or `IDLE` according to the accept.
- `mem_valid` outside `WAIT_MEM` is ignored unless it coincides with an accept that selects `MEM_SRC`.
- Forwarding:
  - `fwd_valid=1` in `WRITE`. `fwd_addr`/`fwd_data` equal `rf_wa`/`rf_wd`.
  - In `WAIT_MEM`: `fwd_valid=0`, `fwd_addr` = latched address. Upstream stalls on an address match.
- Writes to x0 never assert `rf_we`.

## Timing

- Reset values:
  - State `IDLE`; `rf_we=0`, `rf_wa=0`, `rf_wd=0`.
  - `fwd_valid=0`, `fwd_addr=0`, `fwd_data=0`, `busy=0`.
  - `in_ready=1` once `rst` deasserts (0 while asserted).
- Latency:
  - Non-memory source: accept at edge N, `rf_we` high in cycle N+1.
  - Memory source: `mem_valid` at edge M, `rf_we` high in cycle M+1.
- Throughput: one write per cycle for back-to-back non-memory requests.
- `rf_we`, `rf_wa`, `rf_wd` and `fwd_*` are registered; there is no combinational path from inputs.
- `in_ready` and `busy` are decoded from state only.
- Reset mid-operation (`WAIT_MEM` or `WRITE`) aborts immediately. The pending write is dropped, and a later `mem_valid` does not cause a write.

## Structure

- The shared package `otter_pkg` holds:
  - the `wb_state_t` enum (`IDLE`, `WAIT_MEM`, `WRITE`);
  - the select constants `WB_SEL_PC4=0`, `WB_SEL_CSR=1`, `WB_SEL_MEM=2`, `WB_SEL_ALU=3`;
  - `RF_ADDR_W=5`.
- One sub-module, `wb_src_mux`: a parametrised combinational `NSRC:1` selector with out-of-range clamping to the last source. It is instantiated once.

## Test plan

1. Reset, then `sel=3`, `rd=5`, ALU=`0xDEADBEEF`, `in_valid` for one cycle -> next cycle `rf_we=1`, `rf_wa=5`, `rf_wd=0xDEADBEEF`, `fwd_valid=1`; then idle.
2. `sel=2`, `rd=7`, `mem_valid=0` for 3 cycles, then `mem_valid=1` with DOUT2=`0x12345678` -> `busy=1` and `in_ready=0` for 3 cycles; `rf_we` one cycle after `mem_valid`, `rf_wd=0x12345678`.
3. Four back-to-back accepts with `sel=0/1/3/0` and `rd=1..4` -> `rf_we` high for 4 consecutive cycles with matching address and data, and `in_ready` never low.
4. `rd_addr=0`, or `rf_wr_en=0`, with any sel -> `rf_we` never asserts and `fwd_valid` stays 0.
5. Assert `rst` while in `WAIT_MEM`, release it, then pulse `mem_valid` -> no write; all outputs at reset values.
6. `NSRC=6`, `sel=7` -> data taken from source 5. `sel=2` with `mem_valid=1` in the accept cycle -> write the next cycle, without entering `WAIT_MEM`.
